// File: rtl/ramio_bram_if.sv
// RAMIO bus bundle between the core (master) and the block-RAM responder (slave).
interface ramio_bram_if;
  logic        enable;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  modport master (
    output enable, write_type, read_type, address, data_in,
    input  data_out, data_out_ready, busy
  );

  modport slave (
    input  enable, write_type, read_type, address, data_in,
    output data_out, data_out_ready, busy
  );
endinterface

// File: rtl/ramio_bram.sv
// RAMIO responder: byte/half/word access to a word-wide block RAM, misaligned
// accesses split over two words. Define RAMIO_LED_EN to map a 4-bit LED register at LED_ADDR.
module ramio_bram #(
  parameter int          ADDR_WIDTH = 21,
  parameter logic [31:0] LED_ADDR   = 32'hFFFF_FFFC
) (
  input  logic          clk,
  input  logic          rst,
  ramio_bram_if.slave   bus
`ifdef RAMIO_LED_EN
  ,
  output logic [3:0]    led
`endif
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2, RDW} state_e;

  state_e        state_q;
  logic          enable_q, busy_q, ready_q;
  logic [31:0]   dout_q, data_q, word0_q, ramRdata_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          sext_q, span_q, ledHit_q;
`ifdef RAMIO_LED_EN
  logic [3:0]    led_q;
`endif

  logic [31:0]   mem [DEPTH];

  logic          accept, isWrite, ledHitReq, reqSpan;
  logic [2:0]    reqSize;
  logic [3:0]    sizeMask;
  logic [7:0]    be8;
  logic [63:0]   wdata64, rdWord64;
  logic [31:0]   rdLow, rdExt, ramWdata;
  logic [3:0]    ramWe;
  logic [IW-1:0] ramAddr;
  logic          unusedBits;

  assign accept  = (state_q == IDLE) && bus.enable && !enable_q;
  assign isWrite = (bus.write_type != 2'b00);

`ifdef RAMIO_LED_EN
  assign ledHitReq  = (bus.address == LED_ADDR);
  assign unusedBits = ^{bus.address[31:ADDR_WIDTH]};
`else
  assign ledHitReq  = 1'b0;
  assign unusedBits = ^{bus.address[31:ADDR_WIDTH], LED_ADDR};
`endif

  always_comb begin
    reqSize = 3'd0;
    case (isWrite ? bus.write_type : bus.read_type[1:0])
      2'b01:   reqSize = 3'd1;
      2'b10:   reqSize = 3'd2;
      2'b11:   reqSize = 3'd4;
      default: reqSize = 3'd0;
    endcase
  end

  assign reqSpan = ({2'b00, bus.address[1:0]} + {1'b0, reqSize}) > 4'd4;

  // Lanes are laid out over a 64-bit window: low half is word 0, high half is word 1.
  always_comb begin
    sizeMask = 4'b0000;
    case (size_q)
      3'd1:    sizeMask = 4'b0001;
      3'd2:    sizeMask = 4'b0011;
      3'd4:    sizeMask = 4'b1111;
      default: sizeMask = 4'b0000;
    endcase
  end

  assign be8      = {4'b0000, sizeMask} << off_q;
  assign wdata64  = {32'b0, data_q} << {off_q, 3'b000};
  assign rdWord64 = span_q ? {ramRdata_q, word0_q} : {32'b0, ramRdata_q};
  assign rdLow    = 32'(rdWord64 >> {off_q, 3'b000});

  always_comb begin
    rdExt = rdLow;
    case (size_q)
      3'd1:    rdExt = {{24{sext_q & rdLow[7]}}, rdLow[7:0]};
      3'd2:    rdExt = {{16{sext_q & rdLow[15]}}, rdLow[15:0]};
      default: rdExt = rdLow;
    endcase
  end

  always_comb begin
    ramWe    = 4'b0000;
    ramWdata = wdata64[31:0];
    ramAddr  = idx_q;
    if (state_q == WR1 && !ledHit_q) begin
      ramWe = be8[3:0];
    end else if (state_q == WR2) begin
      ramWe    = be8[7:4];
      ramWdata = wdata64[63:32];
    end
    if (state_q == WR2 || state_q == RD2) begin
      ramAddr = IW'(idx_q + 1'b1);
    end
  end

  // Block RAM: never reset, one-cycle registered read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ramWe[b]) begin
        mem[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
      end
    end
    ramRdata_q <= mem[ramAddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      dout_q   <= 32'b0;
      data_q   <= 32'b0;
      word0_q  <= 32'b0;
      idx_q    <= '0;
      off_q    <= 2'b00;
      size_q   <= 3'd0;
      sext_q   <= 1'b0;
      span_q   <= 1'b0;
      ledHit_q <= 1'b0;
`ifdef RAMIO_LED_EN
      led_q    <= 4'hF;
`endif
    end else begin
      enable_q <= bus.enable;
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q   <= bus.data_in;
            idx_q    <= bus.address[ADDR_WIDTH-1:2];
            off_q    <= bus.address[1:0];
            size_q   <= reqSize;
            sext_q   <= bus.read_type[2];
            ledHit_q <= ledHitReq && (reqSize != 3'd0);
            span_q   <= reqSpan && !ledHitReq;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            // A no-op rides through WR1 with no byte enables set.
            state_q  <= (isWrite || reqSize == 3'd0) ? WR1 : RD1;
          end
        end
        WR1: begin
`ifdef RAMIO_LED_EN
          if (ledHit_q) begin
            led_q <= ~data_q[3:0];
          end
`endif
          if (span_q) begin
            state_q <= WR2;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        WR2: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        RD1: begin
          state_q <= span_q ? RD2 : RDW;
        end
        RD2: begin
          word0_q <= ramRdata_q;
          state_q <= RDW;
        end
        RDW: begin
`ifdef RAMIO_LED_EN
          dout_q <= ledHit_q ? {28'b0, ~led_q} : rdExt;
`else
          dout_q <= rdExt;
`endif
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.data_out_ready = ready_q;
  assign bus.busy           = busy_q;
`ifdef RAMIO_LED_EN
  assign led = led_q;
`endif

endmodule

// File: tb/tb_ramio_bram.sv
// Self-checking bench for ramio_bram: directed scenarios plus random traffic
// checked against a byte-addressed memory model.
module tb_ramio_bram;
  localparam int          ADDR_WIDTH = 21;
  localparam logic [31:0] LED_ADDR   = 32'hFFFF_FFFC;
  localparam logic [31:0] AMASK      = (32'd1 << ADDR_WIDTH) - 32'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] refMem [int unsigned];
`ifdef RAMIO_LED_EN
  logic [3:0] led;
  logic [3:0] ledModel = 4'hF;
`endif

  ramio_bram_if bus ();

  ramio_bram #(.ADDR_WIDTH(ADDR_WIDTH), .LED_ADDR(LED_ADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef RAMIO_LED_EN
    ,
    .led (led)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sizeOf(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] byteAddr(input logic [31:0] addr, input int i);
    return (addr + 32'(i)) & AMASK;
  endfunction

  task automatic refWrite(input logic [1:0] wt, input logic [31:0] addr, input logic [31:0] din);
    for (int i = 0; i < sizeOf(wt); i++) refMem[byteAddr(addr, i)] = din[8*i +: 8];
  endtask

  function automatic logic [31:0] refRead(input logic [2:0] rt, input logic [31:0] addr);
    logic [31:0] val;
    int n;
    val = 32'b0;
    n = sizeOf(rt[1:0]);
    for (int i = 0; i < n; i++) val[8*i +: 8] = refMem[byteAddr(addr, i)];
    if (rt[2] && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
    return val;
  endfunction

  // One complete request: drive, accept, measure busy length, compare against the model.
  task automatic applyStimulus(input logic [1:0] wt, input logic [2:0] rt,
                               input logic [31:0] addr, input logic [31:0] din);
    bit          isRead, span, ledHit;
    int          n, lat, expLat;
    logic [31:0] exp;
    isRead = (wt == 2'b00) && (rt[1:0] != 2'b00);
    n      = isRead ? sizeOf(rt[1:0]) : sizeOf(wt);
    span   = (int'(addr[1:0]) + n) > 4;
    ledHit = 1'b0;
`ifdef RAMIO_LED_EN
    ledHit = (addr == LED_ADDR) && (n != 0);
`endif
    if (ledHit) span = 1'b0;
    expLat = isRead ? (span ? 3 : 2) : (span ? 2 : 1);
    exp    = 32'b0;
    if (isRead) begin
`ifdef RAMIO_LED_EN
      if (ledHit) exp = {28'b0, ~ledModel};
      else exp = refRead(rt, addr);
`else
      exp = refRead(rt, addr);
`endif
    end
    @(negedge clk);
    bus.write_type = wt;
    bus.read_type  = rt;
    bus.address    = addr;
    bus.data_in    = din;
    bus.enable     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.enable = 1'b0;
    checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
    checkOutput("ready_cleared", 32'(bus.data_out_ready), 32'd0);
    lat = 0;
    while (bus.busy === 1'b1 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 32'(lat), 32'(expLat));
    if (isRead) begin
      checkOutput("read_ready", 32'(bus.data_out_ready), 32'd1);
      checkOutput("read_data", bus.data_out, exp);
    end else if (wt != 2'b00) begin
`ifdef RAMIO_LED_EN
      if (ledHit) ledModel = ~din[3:0];
      else refWrite(wt, addr, din);
`else
      refWrite(wt, addr, din);
`endif
    end
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  wt;
    logic [2:0]  rt;
    int          cnt, r;

    bus.enable = 1'b0;
    bus.write_type = 2'b00;
    bus.read_type = 3'b000;
    bus.address = 32'b0;
    bus.data_in = 32'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_ready", 32'(bus.data_out_ready), 32'd0);
    checkOutput("reset_dout", bus.data_out, 32'd0);
`ifdef RAMIO_LED_EN
    checkOutput("reset_led", 32'(led), 32'hF);
`endif
    rst = 1'b0;

    $display("[TB] filling test regions");
    for (int w = 0; w < 16; w++) applyStimulus(2'b11, 3'b000, 32'(4*w), $urandom);
    applyStimulus(2'b11, 3'b000, 32'h001F_FFF8, $urandom);
    applyStimulus(2'b11, 3'b000, 32'h001F_FFFC, $urandom);

    $display("[TB] directed: aligned word write, half read");
    applyStimulus(2'b11, 3'b000, 32'h4, 32'h1234_4120);
    applyStimulus(2'b00, 3'b010, 32'h4, 32'h0);
    checkOutput("t1_half", bus.data_out, 32'h0000_4120);

    $display("[TB] directed: byte write, signed and unsigned byte read");
    applyStimulus(2'b01, 3'b000, 32'h9, 32'h0000_0080);
    applyStimulus(2'b00, 3'b101, 32'h9, 32'h0);
    checkOutput("t2_sbyte", bus.data_out, 32'hFFFF_FF80);
    applyStimulus(2'b00, 3'b001, 32'h9, 32'h0);
    checkOutput("t2_ubyte", bus.data_out, 32'h0000_0080);

    $display("[TB] directed: spanning word write and reads");
    applyStimulus(2'b11, 3'b000, 32'h6, 32'hAABB_CCDD);
    applyStimulus(2'b00, 3'b011, 32'h4, 32'h0);
    checkOutput("t3_word4", bus.data_out, 32'hCCDD_4120);
    applyStimulus(2'b00, 3'b011, 32'h6, 32'h0);
    checkOutput("t3_word6", bus.data_out, 32'hAABB_CCDD);
    repeat (3) @(negedge clk);
    checkOutput("t3_hold_data", bus.data_out, 32'hAABB_CCDD);
    checkOutput("t3_hold_ready", 32'(bus.data_out_ready), 32'd1);
    applyStimulus(2'b00, 3'b000, 32'h6, 32'h0);
    checkOutput("noop_ready", 32'(bus.data_out_ready), 32'd0);

    $display("[TB] directed: enable held high");
    @(negedge clk);
    bus.write_type = 2'b11;
    bus.read_type  = 3'b000;
    bus.address    = 32'h20;
    bus.data_in    = 32'h1111_2222;
    bus.enable     = 1'b1;
    @(posedge clk);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      bus.data_in = 32'h3333_4444;
      if (bus.busy === 1'b1) cnt++;
    end
    bus.enable = 1'b0;
    checkOutput("t4_held_busy", 32'(cnt), 32'd1);
    refWrite(2'b11, 32'h20, 32'h1111_2222);
    applyStimulus(2'b00, 3'b011, 32'h20, 32'h0);
    checkOutput("t4_held_data", bus.data_out, 32'h1111_2222);

    $display("[TB] directed: enable edge while busy");
    @(negedge clk);
    bus.write_type = 2'b11;
    bus.address    = 32'h22;
    bus.data_in    = 32'h5555_6666;
    bus.enable     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.enable = 1'b0;
    cnt = (bus.busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    if (bus.busy === 1'b1) cnt++;
    bus.address = 32'h30;
    bus.data_in = 32'h7777_8888;
    bus.enable  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cnt++;
    end
    bus.enable = 1'b0;
    checkOutput("t4_drop_busy", 32'(cnt), 32'd2);
    refWrite(2'b11, 32'h22, 32'h5555_6666);
    applyStimulus(2'b00, 3'b011, 32'h30, 32'h0);
    applyStimulus(2'b00, 3'b011, 32'h22, 32'h0);
    checkOutput("t4_span_data", bus.data_out, 32'h5555_6666);

    $display("[TB] directed: reset during second read phase");
    @(negedge clk);
    bus.write_type = 2'b00;
    bus.read_type  = 3'b011;
    bus.address    = 32'h6;
    bus.enable     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_ready", 32'(bus.data_out_ready), 32'd0);
    checkOutput("t5_dout", bus.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef RAMIO_LED_EN
    ledModel = 4'hF;
`endif
    applyStimulus(2'b00, 3'b011, 32'h6, 32'h0);
    checkOutput("t5_reread", bus.data_out, 32'hAABB_CCDD);

`ifdef RAMIO_LED_EN
    $display("[TB] directed: LED register");
    applyStimulus(2'b11, 3'b000, LED_ADDR, 32'h0000_0003);
    checkOutput("t6_led", 32'(led), 32'hC);
    applyStimulus(2'b00, 3'b011, LED_ADDR, 32'h0);
    checkOutput("t6_led_read", bus.data_out, 32'h0000_0003);
`endif

    $display("[TB] random traffic");
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) a = 32'h001F_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 59));
      a = a | ($urandom & 32'hFFE0_0000);
      if (a == LED_ADDR) a[31] = 1'b0;
      d = $urandom;
      r = $urandom_range(0, 9);
      wt = 2'($urandom_range(1, 3));
      rt[1:0] = 2'($urandom_range(1, 3));
      rt[2] = 1'($urandom_range(0, 1));
      if (r == 0) applyStimulus(2'b00, 3'b000, a, d);
      else if (r < 5) applyStimulus(wt, 3'b000, a, d);
      else applyStimulus(2'b00, rt, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
